zoom_scaler_engine: RTL

- Parametrised image-scaling engine for the zoom coprocessor. It replaces the fixed 320x240, 8-bit algorithm sequencing with runtime source dimensions, configurable pixel width and address width, and a proper command/done handshake with error reporting.
- It owns a single-port synchronous frame memory while busy. It reads a source region and writes the scaled result to a destination region.
- The display path takes the memory port back whenever busy is low.

---
 rtl/zoom_scaler_engine.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/zoom_scaler_engine.sv
// Zoom coprocessor scaling engine: copy, x2 replication, /2 block average and /2 decimation
// over a single-port synchronous frame memory, with a command/done/err handshake.
module zoom_scaler_engine #(
  parameter int PIXEL_W = 8,
  parameter int ADDR_W  = 18,
  parameter int DIM_W   = 10,
  parameter int MAX_W   = 640,
  parameter int MAX_H   = 480
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [DIM_W-1:0]   src_w,
  input  logic [DIM_W-1:0]   src_h,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [PIXEL_W-1:0] mem_wdata,
  output logic               mem_wren,
  input  logic [PIXEL_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_CAP  = 3'd3,
    S_WR      = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam logic [1:0] M_ZIN = 2'd1;
  localparam logic [1:0] M_AVG = 2'd2;
  localparam logic [DIM_W+1:0] MAX_W_L = (DIM_W+2)'(MAX_W);
  localparam logic [DIM_W+1:0] MAX_H_L = (DIM_W+2)'(MAX_H);

  state_t               state_r;
  logic [1:0]           mode_r;
  logic [DIM_W-1:0]     w_r, h_r, gx_r, gy_r;
  logic [ADDR_W-1:0]    srow_r, drow_r;
  logic [1:0]           rd_idx_r, wr_idx_r;
  logic [PIXEL_W+1:0]   acc_r;
  logic                 err_pend_r;
  logic                 cmd_ready_r, busy_r, done_r, err_r, mem_wren_r;
  logic [ADDR_W-1:0]    mem_addr_r;
  logic [PIXEL_W-1:0]   mem_wdata_r;

  logic                 half_s, zin_s, last_rd_s, last_wr_s, last_col_s, last_row_s, check_err_s;
  logic [ADDR_W-1:0]    w_a_s, dst_w_s, src_step_s, dst_step_s, nx_srow_s, nx_drow_s;
  logic [DIM_W-1:0]     gw_s, gh_s, nx_gx_s;
  logic [PIXEL_W+1:0]   rnd_s;
  logic [PIXEL_W-1:0]   avg_s;

  // Source pixel address inside a group: idx[0] steps one column, idx[1] steps one row.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [ADDR_W-1:0] row, input logic [DIM_W-1:0] col,
                                                 input logic [1:0] idx, input logic half, input logic [ADDR_W-1:0] w);
    logic [ADDR_W-1:0] c;
    c = half ? (ADDR_W'(col) << 1) : ADDR_W'(col);
    return row + c + ADDR_W'(idx[0]) + (idx[1] ? w : {ADDR_W{1'b0}});
  endfunction

  function automatic logic [ADDR_W-1:0] dst_addr(input logic [ADDR_W-1:0] row, input logic [DIM_W-1:0] col,
                                                 input logic [1:0] idx, input logic zin, input logic [ADDR_W-1:0] dw);
    logic [ADDR_W-1:0] c;
    c = zin ? (ADDR_W'(col) << 1) : ADDR_W'(col);
    return row + c + ADDR_W'(idx[0]) + (idx[1] ? dw : {ADDR_W{1'b0}});
  endfunction

  // Group geometry, row-pointer steps, averaging and command validation.
  always_comb begin
    half_s     = mode_r[1];
    zin_s      = (mode_r == M_ZIN);
    w_a_s      = ADDR_W'(w_r);
    gw_s       = half_s ? (w_r >> 1) : w_r;
    gh_s       = half_s ? (h_r >> 1) : h_r;
    dst_w_s    = zin_s ? (w_a_s << 1) : (half_s ? (w_a_s >> 1) : w_a_s);
    src_step_s = half_s ? (w_a_s << 1) : w_a_s;
    dst_step_s = zin_s ? (w_a_s << 2) : dst_w_s;
    last_rd_s  = (mode_r == M_AVG) ? (rd_idx_r == 2'd3) : 1'b1;
    last_wr_s  = zin_s ? (wr_idx_r == 2'd3) : 1'b1;
    last_col_s = (gx_r == gw_s - DIM_W'(1));
    last_row_s = (gy_r == gh_s - DIM_W'(1));
    nx_gx_s    = last_col_s ? {DIM_W{1'b0}} : gx_r + DIM_W'(1);
    nx_srow_s  = last_col_s ? srow_r + src_step_s : srow_r;
    nx_drow_s  = last_col_s ? drow_r + dst_step_s : drow_r;
    // Four pixels plus the rounding constant fit in PIXEL_W+2 bits.
    rnd_s      = acc_r + (PIXEL_W+2)'(mem_rdata) + (PIXEL_W+2)'(2);
    avg_s      = PIXEL_W'(rnd_s >> 2);
    if (w_r == {DIM_W{1'b0}} || h_r == {DIM_W{1'b0}}) begin
      check_err_s = 1'b1;
    end else if (zin_s) begin
      check_err_s = ({1'b0, w_r, 1'b0} > MAX_W_L) || ({1'b0, h_r, 1'b0} > MAX_H_L);
    end else if (half_s) begin
      check_err_s = w_r[0] | h_r[0];
    end else begin
      check_err_s = 1'b0;
    end
  end

  // Command sequencer; all outputs are registered and set on the edge entering each state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      mode_r      <= 2'd0;
      w_r         <= {DIM_W{1'b0}};
      h_r         <= {DIM_W{1'b0}};
      gx_r        <= {DIM_W{1'b0}};
      gy_r        <= {DIM_W{1'b0}};
      srow_r      <= {ADDR_W{1'b0}};
      drow_r      <= {ADDR_W{1'b0}};
      rd_idx_r    <= 2'd0;
      wr_idx_r    <= 2'd0;
      acc_r       <= {(PIXEL_W+2){1'b0}};
      err_pend_r  <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      mem_wren_r  <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {PIXEL_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            mode_r      <= cmd_mode;
            w_r         <= src_w;
            h_r         <= src_h;
            srow_r      <= src_base;
            drow_r      <= dst_base;
            gx_r        <= {DIM_W{1'b0}};
            gy_r        <= {DIM_W{1'b0}};
            rd_idx_r    <= 2'd0;
            wr_idx_r    <= 2'd0;
            acc_r       <= {(PIXEL_W+2){1'b0}};
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= S_CHECK;
          end else begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        S_CHECK: begin
          if (check_err_s) begin
            err_pend_r <= 1'b1;
            state_r    <= S_FIN;
          end else begin
            mem_addr_r <= src_addr(srow_r, gx_r, 2'd0, half_s, w_a_s);
            state_r    <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: state_r <= S_RD_CAP;
        S_RD_CAP: begin
          if (!last_rd_s) begin
            acc_r      <= acc_r + (PIXEL_W+2)'(mem_rdata);
            rd_idx_r   <= rd_idx_r + 2'd1;
            mem_addr_r <= src_addr(srow_r, gx_r, rd_idx_r + 2'd1, half_s, w_a_s);
            state_r    <= S_RD_ADDR;
          end else begin
            acc_r       <= {(PIXEL_W+2){1'b0}};
            rd_idx_r    <= 2'd0;
            wr_idx_r    <= 2'd0;
            mem_wdata_r <= (mode_r == M_AVG) ? avg_s : mem_rdata;
            mem_addr_r  <= dst_addr(drow_r, gx_r, 2'd0, zin_s, dst_w_s);
            mem_wren_r  <= 1'b1;
            state_r     <= S_WR;
          end
        end
        S_WR: begin
          if (!last_wr_s) begin
            wr_idx_r   <= wr_idx_r + 2'd1;
            mem_addr_r <= dst_addr(drow_r, gx_r, wr_idx_r + 2'd1, zin_s, dst_w_s);
          end else begin
            mem_wren_r <= 1'b0;
            wr_idx_r   <= 2'd0;
            if (last_col_s && last_row_s) begin
              done_r  <= 1'b1;
              err_r   <= 1'b0;
              state_r <= S_FIN;
            end else begin
              gx_r       <= nx_gx_s;
              gy_r       <= last_col_s ? gy_r + DIM_W'(1) : gy_r;
              srow_r     <= nx_srow_s;
              drow_r     <= nx_drow_s;
              mem_addr_r <= src_addr(nx_srow_s, nx_gx_s, 2'd0, half_s, w_a_s);
              state_r    <= S_RD_ADDR;
            end
          end
        end
        S_FIN: begin
          // A rejected command spends one extra FIN cycle before raising done/err.
          if (err_pend_r) begin
            err_pend_r <= 1'b0;
            done_r     <= 1'b1;
            err_r      <= 1'b1;
          end else begin
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          mem_wren_r  <= 1'b0;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wren  = mem_wren_r;

endmodule
